// File: rtl/game_input_pkg.sv
// Shared definitions for the game_input block: register map and flag helper.
package game_input_pkg;

    typedef enum logic [1:0] {
        REG_STATE      = 2'd0,
        REG_PRESSED    = 2'd1,
        REG_RELEASED   = 2'd2,
        REG_IRQ_ENABLE = 2'd3
    } reg_addr_e;

    localparam int unsigned REG_WIDTH = 16;

    // Sticky flag update: a 1 in clr clears, a 1 in set sets, set wins.
    function automatic logic [REG_WIDTH-1:0] w1c_update(
        input logic [REG_WIDTH-1:0] flags,
        input logic [REG_WIDTH-1:0] clr,
        input logic [REG_WIDTH-1:0] set
    );
        return (flags & ~clr) | set;
    endfunction

endpackage

// File: rtl/game_input_debounce_channel.sv
// One switch channel: polarity fix, 2-flop synchroniser, saturating debounce
// counter and stable level with single-cycle rise/fall pulses.
module debounce_channel #(
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter logic        INVERT        = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic pin_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);

    logic                     sync1_q, sync2_q;
    logic                     stable_q, stable_d;
    logic [DEBOUNCE_BITS-1:0] cnt_q, cnt_d;

    // Synchroniser, counter and stable level registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= pin_i ^ INVERT;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    // Count consecutive mismatches; commit the new level once the counter is full.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        rise_o   = 1'b0;
        fall_o   = 1'b0;
        if (sync2_q != stable_q) begin
            if (cnt_q == '1) begin
                stable_d = sync2_q;
                rise_o   = sync2_q;
                fall_o   = ~sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/game_input.sv
// Debounced switch/joystick input block with sticky press/release flags,
// a small register file and a level interrupt.
module game_input
    import game_input_pkg::*;
#(
    parameter int unsigned CHANNELS      = 9,
    parameter int unsigned DEBOUNCE_BITS = 16,
    parameter logic [15:0] ACTIVE_LOW    = 16'h01ff
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] pins,
    input  logic [1:0]          address,
    input  logic [15:0]         data_in,
    input  logic                write_enable,
    output logic [15:0]         data_out,
    output logic [CHANNELS-1:0] state,
    output logic                interrupt
);

    localparam logic [15:0] CH_MASK = 16'((32'd1 << CHANNELS) - 32'd1);

    // Channel outputs are widened to the register width; unused lanes tie to 0.
    logic [15:0] stable_w, rise_w, fall_w;

    logic [15:0] pressed_q, pressed_d;
    logic [15:0] released_q, released_d;
    logic [15:0] irq_en_q, irq_en_d;
    logic [15:0] rdata_q, rdata_d;
    logic        irq_q, irq_d;

    for (genvar g = 0; g < 16; g++) begin : g_ch
        if (g < CHANNELS) begin : g_live
            debounce_channel #(
                .DEBOUNCE_BITS (DEBOUNCE_BITS),
                .INVERT        (ACTIVE_LOW[g])
            ) u_ch (
                .clk_i    (clk),
                .rst_i    (reset),
                .pin_i    (pins[g]),
                .stable_o (stable_w[g]),
                .rise_o   (rise_w[g]),
                .fall_o   (fall_w[g])
            );
        end else begin : g_tie
            assign stable_w[g] = 1'b0;
            assign rise_w[g]   = 1'b0;
            assign fall_w[g]   = 1'b0;
        end
    end

    // Flag updates, enable write, read mux and interrupt next-state.
    always_comb begin
        logic [15:0] clr_p, clr_r;
        clr_p    = (write_enable && address == REG_PRESSED)  ? data_in : '0;
        clr_r    = (write_enable && address == REG_RELEASED) ? data_in : '0;
        pressed_d  = w1c_update(pressed_q, clr_p, rise_w);
        released_d = w1c_update(released_q, clr_r, fall_w);
        irq_en_d = irq_en_q;
        if (write_enable && address == REG_IRQ_ENABLE) begin
            irq_en_d = data_in & CH_MASK;
        end
        // Read data reflects register contents before this cycle's write.
        case (reg_addr_e'(address))
            REG_STATE:      rdata_d = stable_w;
            REG_PRESSED:    rdata_d = pressed_q;
            REG_RELEASED:   rdata_d = released_q;
            REG_IRQ_ENABLE: rdata_d = irq_en_q;
            default:        rdata_d = '0;
        endcase
        irq_d = |((pressed_q | released_q) & irq_en_q);
    end

    // Register file, read data and interrupt registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pressed_q  <= '0;
            released_q <= '0;
            irq_en_q   <= '0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            pressed_q  <= pressed_d;
            released_q <= released_d;
            irq_en_q   <= irq_en_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign state     = stable_w[CHANNELS-1:0];
    assign data_out  = rdata_q;
    assign interrupt = irq_q;

endmodule

// File: tb/tb_game_input.sv
// Directed bench for game_input with CHANNELS=9, DEBOUNCE_BITS=4, all pins active-low.
module tb_game_input;
    import game_input_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  pins;
    logic [1:0]  address;
    logic [15:0] data_in;
    logic        write_enable;
    logic [15:0] data_out;
    logic [8:0]  state;
    logic        interrupt;

    int total = 0;
    int bad   = 0;
    logic [15:0] rd;

    game_input #(
        .CHANNELS      (9),
        .DEBOUNCE_BITS (4),
        .ACTIVE_LOW    (16'h01ff)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .pins         (pins),
        .address      (address),
        .data_in      (data_in),
        .write_enable (write_enable),
        .data_out     (data_out),
        .state        (state),
        .interrupt    (interrupt)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd_reg(input logic [1:0] a, output logic [15:0] v);
        address = a;
        tick();
        v = data_out;
    endtask

    task automatic wr_reg(input logic [1:0] a, input logic [15:0] v);
        address      = a;
        data_in      = v;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        data_in      = '0;
    endtask

    initial begin
        reset        = 1'b1;
        pins         = 9'h1ff;
        address      = 2'd0;
        data_in      = '0;
        write_enable = 1'b0;
        tick(3);
        check("rst_state", 16'(state), 16'h0000);
        check("rst_dout", data_out, 16'h0000);
        check("rst_irq", 16'(interrupt), 16'h0000);
        reset = 1'b0;

        // Idle pulled-up pins: nothing happens.
        for (int i = 0; i < 100; i++) begin
            tick();
            check("idle_state", 16'(state), 16'h0000);
            check("idle_irq", 16'(interrupt), 16'h0000);
        end
        rd_reg(REG_PRESSED, rd);  check("idle_pressed", rd, 16'h0000);
        rd_reg(REG_RELEASED, rd); check("idle_released", rd, 16'h0000);

        // Press pin0: stable after exactly 18 edges.
        pins[0] = 1'b0;
        tick(17);
        check("p0_early", 16'(state), 16'h0000);
        tick();
        check("p0_on", 16'(state), 16'h0001);
        rd_reg(REG_PRESSED, rd);  check("p0_pressed", rd, 16'h0001);
        rd_reg(REG_STATE, rd);    check("p0_statereg", rd, 16'h0001);
        rd_reg(REG_RELEASED, rd); check("p0_released", rd, 16'h0000);
        check("p0_irq_off", 16'(interrupt), 16'h0000);

        // Glitch on pin3 shorter than the debounce window.
        pins[3] = 1'b0;
        tick(10);
        pins[3] = 1'b1;
        tick(30);
        check("glitch_state", 16'(state), 16'h0001);
        rd_reg(REG_PRESSED, rd); check("glitch_pressed", rd, 16'h0001);

        // W1C clears PRESSED; STATE is read-only.
        wr_reg(REG_PRESSED, 16'h0001);
        rd_reg(REG_PRESSED, rd); check("w1c_pressed", rd, 16'h0000);
        wr_reg(REG_STATE, 16'hffff);
        rd_reg(REG_STATE, rd);   check("state_ro", rd, 16'h0001);

        // Release pin0.
        pins[0] = 1'b1;
        tick(18);
        check("rel_state", 16'(state), 16'h0000);
        rd_reg(REG_RELEASED, rd); check("rel_flag", rd, 16'h0001);
        wr_reg(REG_RELEASED, 16'h0001);
        rd_reg(REG_RELEASED, rd); check("w1c_released", rd, 16'h0000);

        // IRQ enable: upper bits read 0.
        wr_reg(REG_IRQ_ENABLE, 16'hffff);
        rd_reg(REG_IRQ_ENABLE, rd); check("irqen_mask", rd, 16'h01ff);
        wr_reg(REG_IRQ_ENABLE, 16'h0001);
        rd_reg(REG_IRQ_ENABLE, rd); check("irqen_val", rd, 16'h0001);
        check("irq_idle", 16'(interrupt), 16'h0000);

        // Interrupt follows PRESSED by one cycle and drops one cycle after clear.
        pins[0] = 1'b0;
        tick(18);
        check("irq_p_state", 16'(state), 16'h0001);
        check("irq_p_same", 16'(interrupt), 16'h0000);
        tick();
        check("irq_p_set", 16'(interrupt), 16'h0001);
        wr_reg(REG_PRESSED, 16'h0001);
        check("irq_clr_hold", 16'(interrupt), 16'h0001);
        tick();
        check("irq_clr_drop", 16'(interrupt), 16'h0000);

        // Release pin0, clear RELEASED, then collide W1C with a new press.
        pins[0] = 1'b1;
        tick(18);
        check("col_rel", 16'(state), 16'h0000);
        wr_reg(REG_RELEASED, 16'h0001);
        pins[0] = 1'b0;
        tick(17);
        check("col_early", 16'(state), 16'h0000);
        address      = REG_PRESSED;
        data_in      = 16'h0001;
        write_enable = 1'b1;
        tick();
        write_enable = 1'b0;
        data_in      = '0;
        check("col_state", 16'(state), 16'h0001);
        rd_reg(REG_PRESSED, rd); check("col_set_wins", rd, 16'h0001);

        // Asynchronous reset mid-count on pin5.
        pins[5] = 1'b0;
        tick(10);
        #3;
        reset = 1'b1;
        #1;
        check("arst_state", 16'(state), 16'h0000);
        check("arst_dout", data_out, 16'h0000);
        check("arst_irq", 16'(interrupt), 16'h0000);
        tick(2);
        reset = 1'b0;
        tick(17);
        check("post_early", 16'(state), 16'h0000);
        tick();
        check("post_on", 16'(state), 16'h0021);
        rd_reg(REG_PRESSED, rd);    check("post_pressed", rd, 16'h0021);
        rd_reg(REG_IRQ_ENABLE, rd); check("post_irqen", rd, 16'h0000);
        check("post_irq", 16'(interrupt), 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/game_input.md
GAME_INPUT -- requirements
Module: game_input

Interface
REQ-001 Parameter CHANNELS, default 9, is the number of input channels (5 joystick + 4 buttons); legal range 1..16.
REQ-002 Parameter DEBOUNCE_BITS, default 16, is the debounce counter width; legal range 2..24.
REQ-003 Parameter ACTIVE_LOW, default 16'h01ff, is a per-channel mask; a 1 inverts that pin, so pulled-up switches read 1 when pressed.
REQ-004 clk  input  1  single system clock; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 pins  input  CHANNELS  raw asynchronous switch inputs.
REQ-007 address  input  2  register select.
REQ-008 data_in  input  16  write data.
REQ-009 write_enable  input  1  one-cycle write strobe.
REQ-010 data_out  output  16  registered read data.
REQ-011 state  output  CHANNELS  debounced level per channel, 1 = pressed.
REQ-012 interrupt  output  1  registered, level-high event request.

Function
REQ-013 Each pin SHALL be XORed with its ACTIVE_LOW bit, then pass through a 2-flop synchroniser.
REQ-014 Each channel SHALL hold a stable bit and a DEBOUNCE_BITS counter.
REQ-015 Per-cycle channel rule, synchroniser output vs stable: equal -> counter 0; differ and counter < max -> counter+1; differ and counter == max -> stable takes the sync value, counter 0.
REQ-016 A stable change therefore needs 2^DEBOUNCE_BITS consecutive mismatching cycles at the synchroniser output; any glitch shorter than that SHALL leave stable unchanged and restart the count.
REQ-017 A stable 0->1 transition SHALL set that channel's sticky PRESSED bit; a 1->0 transition SHALL set its sticky RELEASED bit.
REQ-018 Register map, read data zero-extended to 16 bits: 0 STATE (RO, writes ignored); 1 PRESSED (W1C); 2 RELEASED (W1C); 3 IRQ_ENABLE (RW, bits CHANNELS-1..0, upper bits read 0).
REQ-019 W1C: when write_enable is high, each data_in bit equal to 1 SHALL clear the matching flag; bits equal to 0 SHALL have no effect.
REQ-020 Simultaneous set and clear of the same flag in one cycle: set SHALL win.
REQ-021 data_out SHALL equal the register selected by the address sampled on the previous clock edge (1-cycle read latency), reflecting flag values before any same-cycle write.
REQ-022 interrupt SHALL be registered as OR over channels of ((PRESSED | RELEASED) & IRQ_ENABLE), asserting one cycle after the flag or enable change and deasserting one cycle after the last contributing flag clears.
REQ-023 state SHALL be driven directly from the stable bits, with no extra delay.

Reset
REQ-024 While reset is high, all of the following SHALL be 0: synchronisers, stable bits, counters, PRESSED, RELEASED, IRQ_ENABLE, data_out and interrupt.
REQ-025 Reset SHALL take effect immediately and asynchronously, including mid-count, aborting any debounce in progress.
REQ-026 An idle pulled-up pin SHALL produce no PRESSED or RELEASED event after reset release, because inversion precedes synchronisation.

Structure
REQ-027 The register address constants (STATE=0, PRESSED=1, RELEASED=2, IRQ_ENABLE=3) SHALL live in shared package game_input_pkg, also used by firmware headers and the bench.
REQ-028 Sub-module debounce_channel SHALL hold the synchroniser, counter, stable bit and edge-pulse outputs for one channel; game_input SHALL instantiate it CHANNELS times through a generate loop.
REQ-029 The register file, W1C logic, read mux and interrupt SHALL reside in game_input.

Verification (CHANNELS=9, DEBOUNCE_BITS=4, ACTIVE_LOW=9'h1ff)
REQ-030 Release reset with all pins high -> state=0, PRESSED=0, RELEASED=0, interrupt=0 for 100 cycles.
REQ-031 Drive pin0 low and hold -> state[0] rises exactly 2+16 cycles after the pin edge; reading address 1 returns 16'h0001.
REQ-032 Toggle pin3 low for 10 cycles, then high -> state[3] stays 0 and PRESSED stays 0.
REQ-033 Write IRQ_ENABLE=16'h0001, then press pin0 -> interrupt=1 one cycle after PRESSED[0] sets; write 16'h0001 to address 1 -> interrupt=0 one cycle later.
REQ-034 Arrange a W1C of PRESSED[0] on the same cycle pin0's press becomes stable -> PRESSED[0] reads 1 afterwards.
REQ-035 Assert reset with pin5 counter at 8 -> all outputs 0 immediately; after release, pin5 held low needs a full 2+16 cycles to set state[5].
